// File: rtl/prog_mem_loader.sv
// prog_mem_loader: 16x8 program memory with a valid/ready byte loader that holds the core in reset while loading.
// Define PROG_MEM_LOADER_CHECKSUM_EN to require a trailing modulo-256 checksum byte after the program.
module prog_mem_loader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8,
    parameter int RELEASE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] instr,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              cpu_n_reset,
    output logic              loading,
    output logic              load_done,
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
    output logic              load_err,
`endif
    output logic [ADDR_W-1:0] wr_ptr
);
    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = RELEASE_CYCLES > 1 ? $clog2(RELEASE_CYCLES) : 1;

    typedef enum logic [2:0] {RUN, LOAD, RELEASE, CHECK, ERROR} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic               done_nx;
    logic               accept, write;

    assign instr  = mem[address];
    assign accept = load_valid & load_ready;
    assign write  = (state == LOAD) & accept & ~load_start;

`ifdef PROG_MEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum;
    assign load_ready = (state == LOAD) || (state == CHECK);
    assign load_err   = state == ERROR;
`else
    assign load_ready = state == LOAD;
`endif
    assign loading = load_ready;

    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        case (state)
            RUN:     state_nx = load_start ? LOAD : RUN;
            LOAD: begin
                if (load_start)
                    state_nx = LOAD;
                else if (accept && &wr_ptr) begin
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
                    state_nx = CHECK;
`else
                    state_nx = RELEASE;
                    done_nx  = 1'b1;
`endif
                end
            end
            RELEASE: state_nx = load_start ? LOAD : (cnt == '0 ? RUN : RELEASE);
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
            CHECK: begin
                if (load_start)
                    state_nx = LOAD;
                else if (accept) begin
                    state_nx = (load_data == sum) ? RELEASE : ERROR;
                    done_nx  = load_data == sum;
                end
            end
            ERROR:   state_nx = load_start ? LOAD : ERROR;
`endif
            default: state_nx = RELEASE;
        endcase
    end

    // cpu_n_reset follows the next state so the core sees it low on the first LOAD edge
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state       <= RELEASE;
            cnt         <= CNT_W'(RELEASE_CYCLES - 1);
            wr_ptr      <= '0;
            cpu_n_reset <= 1'b0;
            load_done   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
            sum         <= '0;
`endif
        end else begin
            state       <= state_nx;
            cnt         <= (state == RELEASE) ? cnt - 1'b1 : CNT_W'(RELEASE_CYCLES - 1);
            cpu_n_reset <= state_nx == RUN;
            load_done   <= done_nx;
            if (load_start)
                wr_ptr <= '0;
            else if (write)
                wr_ptr <= wr_ptr + 1'b1;
            if (write)
                mem[wr_ptr] <= load_data;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
            if (load_start)
                sum <= '0;
            else if (write)
                sum <= sum + load_data;
`endif
        end
    end
endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: scoreboard bench for prog_mem_loader; memory contents are modelled and
// read back through instr, handshake and reset-release timing are checked cycle by cycle.
module tb_prog_mem_loader;
    logic       clk = 1'b0;
    logic       n_reset = 1'b0;
    logic [3:0] address = '0;
    logic [7:0] instr;
    logic       load_start = 1'b0;
    logic       load_valid = 1'b0;
    logic [7:0] load_data = '0;
    logic       load_ready, cpu_n_reset, loading, load_done;
    logic [3:0] wr_ptr;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
    logic       load_err;
`endif

    int         n_checks = 0;
    int         n_pass = 0;
    logic [7:0] model [16];
    logic [3:0] wr_model;
    logic [7:0] csum;
    logic [7:0] exp_q [$];

    always #5 clk = ~clk;

    prog_mem_loader dut (
        .clk(clk),
        .n_reset(n_reset),
        .address(address),
        .instr(instr),
        .load_start(load_start),
        .load_valid(load_valid),
        .load_data(load_data),
        .load_ready(load_ready),
        .cpu_n_reset(cpu_n_reset),
        .loading(loading),
        .load_done(load_done),
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
        .load_err(load_err),
`endif
        .wr_ptr(wr_ptr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic readback();
        for (int a = 0; a < 16; a++) exp_q.push_back(model[a]);
        for (int a = 0; a < 16; a++) begin
            address = 4'(a);
            #1;
            check($sformatf("instr[%0d]", a), 32'(instr), 32'(exp_q.pop_front()));
        end
    endtask

    task automatic reset_checks();
        check("rst cpu_n_reset", 32'(cpu_n_reset), 0);
        check("rst load_ready", 32'(load_ready), 0);
        check("rst loading", 32'(loading), 0);
        check("rst load_done", 32'(load_done), 0);
        check("rst wr_ptr", 32'(wr_ptr), 0);
    endtask

    task automatic release_seq();
        n_reset = 1'b1;
        tick();
        check("release edge1 cpu_n_reset", 32'(cpu_n_reset), 0);
        tick();
        check("release edge2 cpu_n_reset", 32'(cpu_n_reset), 1);
        check("release loading", 32'(loading), 0);
    endtask

    task automatic start_load();
        load_start = 1'b1;
        load_valid = 1'b1;
        load_data  = 8'hEE;
        tick();
        load_start = 1'b0;
        load_valid = 1'b0;
        wr_model   = '0;
        csum       = '0;
        check("start wr_ptr", 32'(wr_ptr), 0);
        check("start loading", 32'(loading), 1);
        check("start cpu_n_reset", 32'(cpu_n_reset), 0);
    endtask

    task automatic stream(input logic [7:0] base, input int n, input bit gapped, input bit inc);
        for (int i = 0; i < n; i++) begin
            if (gapped) begin
                load_valid = 1'b0;
                load_data  = 8'hEE;
                tick();
                check("gap wr_ptr", 32'(wr_ptr), 32'(wr_model));
            end
            load_valid = 1'b1;
            load_data  = inc ? base + 8'(i) : base;
            check("stream load_ready", 32'(load_ready), 1);
            check("stream cpu_n_reset", 32'(cpu_n_reset), 0);
            model[wr_model] = load_data;
            csum = csum + load_data;
            wr_model = wr_model + 1'b1;
            tick();
            check("stream wr_ptr", 32'(wr_ptr), 32'(wr_model));
        end
        load_valid = 1'b0;
    endtask

    task automatic post_load();
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
        check("check loading", 32'(loading), 1);
        check("check load_done", 32'(load_done), 0);
        load_valid = 1'b1;
        load_data  = csum;
        tick();
        load_valid = 1'b0;
`endif
        check("done pulse", 32'(load_done), 1);
        check("done wr_ptr", 32'(wr_ptr), 0);
        check("done load_ready", 32'(load_ready), 0);
        check("done loading", 32'(loading), 0);
        tick();
        check("done pulse end", 32'(load_done), 0);
        check("post edge1 cpu_n_reset", 32'(cpu_n_reset), 0);
        tick();
        check("post edge2 cpu_n_reset", 32'(cpu_n_reset), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) model[i] = '0;
        #12;
        reset_checks();
        readback();
        release_seq();
        readback();

        start_load();
        stream(8'hB0, 16, 1'b0, 1'b1);
        post_load();
        readback();
        address = 4'd5;
        #1;
        check("instr at 5", 32'(instr), 32'h B5);

        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        start_load();
        stream(8'hB0, 16, 1'b1, 1'b1);
        post_load();
        for (int i = 0; i < 16; i++) model[i] = 8'hB0 + 8'(i);
        readback();

        start_load();
        stream(8'h70, 7, 1'b0, 1'b1);
        start_load();
        stream(8'h30, 16, 1'b0, 1'b1);
        post_load();
        readback();

        start_load();
        stream(8'h55, 9, 1'b0, 1'b1);
        n_reset = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) model[i] = '0;
        reset_checks();
        readback();
        tick();
        release_seq();
        readback();

`ifdef PROG_MEM_LOADER_CHECKSUM_EN
        start_load();
        stream(8'h01, 16, 1'b0, 1'b0);
        check("csum value", 32'(csum), 32'h10);
        post_load();
        readback();

        start_load();
        stream(8'h01, 16, 1'b0, 1'b0);
        load_valid = 1'b1;
        load_data  = 8'h11;
        tick();
        load_valid = 1'b0;
        check("err load_err", 32'(load_err), 1);
        check("err load_done", 32'(load_done), 0);
        check("err load_ready", 32'(load_ready), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("err cpu_n_reset", 32'(cpu_n_reset), 0);
        end
        start_load();
        check("err cleared", 32'(load_err), 0);
        stream(8'h40, 16, 1'b0, 1'b1);
        post_load();
        readback();
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/prog_mem_loader.md
Name: prog_mem_loader

Overview:
- 16-entry x 8-bit program memory that sits directly upstream of the 4-bit CPU core.
- Drives `instr` combinationally from the core's `address`.
- Provides a byte-stream load port (valid/ready handshake) so a host can rewrite the program at run time.
- Owns the core's reset: holds `cpu_n_reset` low while loading and for a fixed number of cycles afterwards, so the core's synchronous reset always samples low on at least one clock edge.

Parameters:
- ADDR_W, 4, address width; memory depth is 2**ADDR_W (must match the core's address width).
- DATA_W, 8, instruction width (opcode[7:4], immediate[3:0]).
- RELEASE_CYCLES, 2, cycles `cpu_n_reset` stays low after load completes or after `n_reset` deasserts; minimum 1.

Ports:
- clk  in  1  system clock, rising-edge.
- n_reset  in  1  asynchronous, active-low reset.
- address  in  ADDR_W  fetch address from the core's PC.
- instr  out  DATA_W  instruction at `address`; combinational read.
- load_start  in  1  single-cycle pulse; opens or restarts a load session.
- load_valid  in  1  host presents a byte on `load_data`.
- load_data  in  DATA_W  program byte, written in address order 0..15.
- load_ready  out  1  block accepts a byte this cycle.
- cpu_n_reset  out  1  active-low reset to the core; registered.
- loading  out  1  high in LOAD (and CHECK when compiled in).
- load_done  out  1  one-cycle pulse when the last byte is accepted and validated.
- wr_ptr  out  ADDR_W  next memory write address.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (`clk`, `n_reset`). On `n_reset`=0, asynchronously:
  - all memory words = 8'h00;
  - state = RELEASE, release counter = RELEASE_CYCLES-1, `wr_ptr` = 0;
  - `cpu_n_reset` = 0, `load_ready` = 0, `loading` = 0, `load_done` = 0.
- Read path: `instr` = mem[address], no latency. A write to the addressed word is visible on `instr` the cycle after the accepting edge.
- Write path: a byte is accepted on a rising edge where `load_valid` & `load_ready`.
  - mem[wr_ptr] <= load_data; wr_ptr <= wr_ptr+1, wrapping modulo 2**ADDR_W.
  - The host may hold `load_valid` high; one byte is accepted per cycle.
- States:
  - RUN: `cpu_n_reset`=1, `load_ready`=0. On `load_start`=1 -> LOAD with `wr_ptr`<=0.
  - LOAD: `cpu_n_reset`=0, `load_ready`=1, `loading`=1.
    - When the byte at `wr_ptr`=15 is accepted -> RELEASE (or CHECK with the macro). `load_done` pulses on that transition (or on the CHECK pass transition with the macro).
    - `load_start` in LOAD restarts the session: `wr_ptr`<=0, no byte is written that cycle even if `load_valid`=1, and already-written words are kept.
  - RELEASE: `cpu_n_reset`=0, `load_ready`=0. The counter decrements each cycle; at 0 -> RUN. `load_start` in RELEASE -> LOAD.
- `cpu_n_reset` is a flop updated from the next state, so it is low on the first clock edge in LOAD. The core therefore starts at PC=0 when released.
- `load_start` and a valid byte in the same RUN cycle: the byte is ignored, because `load_ready`=0 in RUN.
- Reset asserted mid-load: the memory is cleared. A partial program is never executed.
- No idle timeout: the block stays in LOAD until 16 bytes are accepted or `load_start` is pulsed.

Optional Feature:
- Macro: PROG_MEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the 16th byte -> CHECK, with `load_ready`=1 and `loading`=1.
  - The next accepted byte is compared with the 8-bit modulo-256 sum of the 16 accepted bytes; the checksum byte is not written to memory.
  - Match -> RELEASE with a `load_done` pulse.
  - Mismatch -> ERROR: `cpu_n_reset`=0, `load_ready`=0, and output `load_err`=1. `load_err` is reset to 0 and cleared on the next `load_start`, which enters LOAD.
  - `load_start` in CHECK restarts LOAD.
- Not defined: no CHECK or ERROR states, no `load_err` port; the 16th byte goes straight to RELEASE.

Test Plan:
- Release after reset: deassert `n_reset` -> `cpu_n_reset` stays 0 for exactly 2 rising edges, then 1. `instr`=8'h00 at every address.
- Full load: pulse `load_start`, stream bytes 8'hB0+i for i=0..15 back-to-back -> `load_ready`=1 for 16 cycles, `wr_ptr` wraps to 0, `load_done` pulses once, `cpu_n_reset` returns to 1 2 cycles later, and `instr` at address 5 = 8'hB5.
- Gapped handshake: `load_valid` toggling every other cycle -> only cycles with valid&ready write; the final contents match the full-load case.
- Restart: pulse `load_start` after 7 bytes, then send 16 new bytes 8'h30+i -> mem[0..15]=8'h30..8'h3F and `cpu_n_reset` stays 0 throughout.
- Mid-load reset: assert `n_reset` after 9 bytes -> all words 8'h00 asynchronously, `load_ready`=0, then the release sequence runs.
- Checksum (macro defined): 16 bytes 8'h01 plus checksum 8'h10 -> `load_done`; checksum 8'h11 instead -> `load_err`=1 and `cpu_n_reset` stays 0 until `load_start`.
